// File: rtl/blit_pkg.sv
// Shared types and constants for the blitter coordinate sequencer.
package blit_pkg;

    localparam int unsigned CW = 16;

    localparam logic [1:0] OP_PEN  = 2'h0;
    localparam logic [1:0] OP_SRC  = 2'h1;
    localparam logic [1:0] OP_MONO = 2'h2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } blit_seq_state_t;

endpackage

// File: rtl/blit_step_counter.sv
// One scan axis: index counter with load/advance, last flag and the offset of the next pixel.
// With BLIT_REVERSE_EN the offset mirrors to size-1-index for reverse scans.
module blit_step_counter
    import blit_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          advance,
    input  logic [CW-1:0] size,
`ifdef BLIT_REVERSE_EN
    input  logic          reverse,
`endif
    output logic          last_c,
    output logic [CW-1:0] offset_c
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign last_c = (count_q == size - CW'(1));

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (advance) begin
            count_d = last_c ? '0 : count_q + CW'(1);
        end
    end

    // Offset of the pixel that p2 will hold after this edge.
`ifdef BLIT_REVERSE_EN
    assign offset_c = reverse ? (size - CW'(1) - count_d) : count_d;
`else
    assign offset_c = count_d;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/blit_coord_gen.sv
// Blitter coordinate sequencer: walks one rectangle command in raster order onto the p2 stage.
// Optional reverse scan is enabled by defining BLIT_REVERSE_EN.
module blit_coord_gen
    import blit_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          stall,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_width,
    input  logic [CW-1:0] cmd_height,
    input  logic [CW-1:0] cmd_dest_x,
    input  logic [CW-1:0] cmd_dest_y,
    input  logic [CW-1:0] cmd_src_x,
    input  logic [CW-1:0] cmd_src_y,
`ifdef BLIT_REVERSE_EN
    input  logic          cmd_reverse,
`endif
    output logic [CW-1:0] p2_dest_x,
    output logic [CW-1:0] p2_dest_y,
    output logic [CW-1:0] p2_src_x,
    output logic [CW-1:0] p2_src_y,
    output logic          p2_write,
    output logic [1:0]    p2_op,
    output logic          busy,
    output logic          done
);

    blit_seq_state_t state_q;
    blit_seq_state_t state_d;

    logic [CW-1:0] w_q, h_q, dx_q, dy_q, sx_q, sy_q;
    logic [CW-1:0] w_sel, h_sel, dx_sel, dy_sel, sx_sel, sy_sel;
    logic [1:0]    op_sel;
    logic          idle_c, accept_c, empty_c, load_c, step_c;
    logic          last_pixel_c, adv_x_c, adv_y_c;
    logic          x_last_c, y_last_c;
    logic [CW-1:0] x_off_c, y_off_c;

    assign idle_c    = (state_q == IDLE);
    assign cmd_ready = idle_c && !stall;
    assign busy      = (state_q == RUN);

    assign accept_c     = cmd_valid && cmd_ready;
    assign empty_c      = (cmd_width == '0) || (cmd_height == '0);
    assign load_c       = accept_c && !empty_c;
    assign step_c       = busy && !stall;
    assign last_pixel_c = x_last_c && y_last_c;
    assign adv_x_c      = step_c && !last_pixel_c;
    assign adv_y_c      = adv_x_c && x_last_c;

    // On the accept edge the command fields are not latched yet, so take them from the port.
    assign w_sel  = idle_c ? cmd_width  : w_q;
    assign h_sel  = idle_c ? cmd_height : h_q;
    assign dx_sel = idle_c ? cmd_dest_x : dx_q;
    assign dy_sel = idle_c ? cmd_dest_y : dy_q;
    assign sx_sel = idle_c ? cmd_src_x  : sx_q;
    assign sy_sel = idle_c ? cmd_src_y  : sy_q;
    assign op_sel = idle_c ? cmd_op     : p2_op;

`ifdef BLIT_REVERSE_EN
    logic rev_q;
    logic rev_sel;
    assign rev_sel = idle_c ? cmd_reverse : rev_q;
`endif

    blit_step_counter u_x_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (load_c),
        .advance  (adv_x_c),
        .size     (w_sel),
`ifdef BLIT_REVERSE_EN
        .reverse  (rev_sel),
`endif
        .last_c   (x_last_c),
        .offset_c (x_off_c)
    );

    blit_step_counter u_y_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (load_c),
        .advance  (adv_y_c),
        .size     (h_sel),
`ifdef BLIT_REVERSE_EN
        .reverse  (rev_sel),
`endif
        .last_c   (y_last_c),
        .offset_c (y_off_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_c) state_d = RUN;
            RUN:     if (step_c && last_pixel_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // p2 stage registers and latched command fields.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_q       <= '0;
            h_q       <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
`ifdef BLIT_REVERSE_EN
            rev_q     <= 1'b0;
`endif
            p2_dest_x <= '0;
            p2_dest_y <= '0;
            p2_src_x  <= '0;
            p2_src_y  <= '0;
            p2_write  <= 1'b0;
            p2_op     <= OP_PEN;
            done      <= 1'b0;
        end else begin
            done <= (accept_c && empty_c) || (step_c && last_pixel_c);
            if (load_c) begin
                w_q      <= cmd_width;
                h_q      <= cmd_height;
                dx_q     <= cmd_dest_x;
                dy_q     <= cmd_dest_y;
                sx_q     <= cmd_src_x;
                sy_q     <= cmd_src_y;
`ifdef BLIT_REVERSE_EN
                rev_q    <= cmd_reverse;
`endif
                p2_op    <= cmd_op;
                p2_write <= 1'b1;
            end else if (step_c && last_pixel_c) begin
                p2_write <= 1'b0;
            end
            if (load_c || adv_x_c) begin
                p2_dest_x <= dx_sel + x_off_c;
                p2_dest_y <= dy_sel + y_off_c;
                p2_src_x  <= (op_sel == OP_PEN) ? '0 : sx_sel + x_off_c;
                p2_src_y  <= (op_sel == OP_PEN) ? '0 : sy_sel + y_off_c;
            end
        end
    end

endmodule

// File: doc/blit_coord_gen.md
# blit_coord_gen

Blitter coordinate sequencer: accepts one rectangle command from the command processor and walks it pixel by pixel, emitting per-pixel destination and source coordinates plus a write strobe into the p2 stage of the blitter pipeline. It is the producer side of the p2 coordinate interface. The address-calculation stage consumes that interface and shares the same pipeline `stall`. Pixels advance one per non-stalled cycle, in raster order: x inner, y outer.

## Interface
Parameters:
- `CW`, 16: coordinate/counter width; fixed by the p2 interface.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `stall` in 1: pipeline stall. p2 registers and counters freeze while high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high when `state==IDLE && !stall`. A command is accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_op` in 2: OP_PEN, OP_SRC or OP_MONO.
- `cmd_width`, `cmd_height` in 16 each: rectangle size in pixels.
- `cmd_dest_x`, `cmd_dest_y` in 16 each: top-left destination pixel.
- `cmd_src_x`, `cmd_src_y` in 16 each: top-left source pixel. Ignored for OP_PEN.
- `cmd_reverse` in 1: reverse scan order. Present only with BLIT_REVERSE_EN.
- `p2_dest_x`, `p2_dest_y`, `p2_src_x`, `p2_src_y` out 16 each: current pixel coordinates.
- `p2_write` out 1: p2 holds a valid pixel.
- `p2_op` out 2: latched `cmd_op`.
- `busy` out 1: `state==RUN`.
- `done` out 1: one-cycle pulse when a command has fully issued.

## Operation
- States: IDLE and RUN. Column counter `i` and row counter `j` describe the pixel currently on p2.
- **IDLE + accept**, with W or H equal to 0:
  - no pixels are emitted; `p2_write` stays 0;
  - `done` pulses on the next cycle; state remains IDLE.
- **IDLE + accept**, otherwise:
  - `i=j=0`;
  - p2 is loaded with the first pixel and `p2_write` is set to 1;
  - `p2_op` is set to `cmd_op`;
  - command fields are latched and state goes to RUN.
- **RUN, non-stalled edge**, pixel is not the last:
  - if `i==W-1`, then `i=0` and `j` is incremented;
  - otherwise `i` is incremented;
  - p2 is loaded with the new pixel and `p2_write` stays 1.
- **RUN, non-stalled edge**, pixel is the last (`i==W-1 && j==H-1`):
  - `p2_write` is cleared;
  - state goes to IDLE and `done` is set.
- **RUN, stalled edge**: every register is held.
- **Pixel coordinates** (forward scan): `dest_x = dx+i`, `dest_y = dy+j`, `src_x = sx+i`, `src_y = sy+j`.
  - Addition is modulo 2^16; wrap-around is legal and is not detected.
  - Clipping is not done here; the downstream stage clips.
- **OP_MONO**: `src_x` is a pixel (bit) coordinate. It is not divided by 8 here.
- **OP_PEN**: `p2_src_x` and `p2_src_y` are driven 0.
- **`done`**:
  - registered and cleared on the following edge, whatever `stall` is;
  - `done` and `cmd_ready` may both be high in the same cycle.
- **Reset**, asynchronous, including mid-command:
  - state goes to IDLE and the in-flight command is discarded;
  - `p2_write`, `done`, `busy`, `p2_*` coordinates and `p2_op` all reset to 0.

## Timing
- Accept on edge N (stall-free): first pixel on p2 during N+1.
- The last pixel is on p2 during N+W·H.
- `done` is high and `cmd_ready` is high during N+W·H+1.
- Back-to-back commands leave one bubble cycle (`p2_write=0`) between them.
- Each stalled cycle adds exactly one cycle to all later events.
- All outputs are registered; `cmd_ready` and `busy` are combinational from state and `stall`.

## Configuration
- **BLIT_REVERSE_EN defined:**
  - the `cmd_reverse` port exists;
  - when `cmd_reverse=1`, the scan starts at offset (W-1, H-1) and runs right-to-left, bottom-to-top;
  - coordinates become `dx+(W-1-i)`, `dy+(H-1-j)`, and the same form for src;
  - this gives a correct overlapping copy when the destination is below or right of the source.
- **BLIT_REVERSE_EN undefined:**
  - the port is absent and only forward scan exists;
  - logic area shrinks by the second adder set.

## Structure
- Package `blit_pkg` holds:
  - OP_PEN=2'h0, OP_SRC=2'h1, OP_MONO=2'h2;
  - the state enum `blit_seq_state_t` (IDLE, RUN).
- Counter width CW lives as a package constant.
- Optional sub-module `blit_step_counter`: one axis counter with load, advance, last-flag and reverse offset. It is instantiated twice, for x and y.

## Test plan
- **Basic 3×2 OP_SRC**: dest (10,20), src (100,200), no stall.
  - Six pixels appear in cycles N+1..N+6.
  - Dest sequence: (10,20), (11,20), (12,20), (10,21), (11,21), (12,21).
  - Src coordinates are offset by (90,180) from dest.
  - `done` is high at N+7.
- **Zero width**: W=0, H=5.
  - `p2_write` never rises.
  - `done` pulses at N+1 and `busy` stays 0.
- **Stall**: 2×2 command, `stall` held high for 3 cycles after the second pixel appears.
  - p2 holds (x+1,y) for those 3 cycles.
  - `done` moves from N+5 to N+8.
  - `cmd_ready` is low during the stall.
- **Wrap**: dest_x=0xFFFE, W=4.
  - Dest x sequence: 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **Mid-command reset**: `reset` asserted asynchronously on pixel 3 of a 4×4 command.
  - `p2_write` and `busy` drop immediately.
  - After release, a new 1×1 command issues normally.
- **Reverse** (BLIT_REVERSE_EN): 2×2 at dest (5,5).
  - Sequence: (6,6), (5,6), (6,5), (5,5).
